// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared state encoding and default sizing for the AXI4-Lite master arbiter.
package axi_lite_arb_pkg;
   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 16;
   localparam int DEF_CNT_W   = 5;
endpackage

// File: rtl/arb_prio_enc.sv
// arb_prio_enc: combinational highest-set-bit encoder with any_valid flag.
module arb_prio_enc #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   output logic [IDX_W-1:0]   idx,
   output logic               any_valid
);
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) if (req[i]) idx = IDX_W'(i);
      any_valid = |req;
   end
endmodule

// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter: registered request arbiter with watchdog release for the shared AXI4-Lite slave.
// Define ROUND_ROBIN_EN to rotate priority so the last served master ranks lowest.
module axi_lite_master_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);
   localparam logic [0:0] ST_IDLE = 1'(IDLE);
   localparam logic [0:0] ST_BUSY = 1'(BUSY);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] wd;
   logic [IDX_W-1:0] enc_idx, win_idx;
   logic             any_req;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] rot;
   logic [IDX_W:0]     sum;
   // rot[j] = req[ptr+j]: top bit is ptr-1, bit 0 is ptr itself (lowest priority)
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) rot[i] = req[IDX_W'((i + int'(ptr)) % NUM_REQ)];
      sum = {1'b0, enc_idx} + {1'b0, ptr};
      win_idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
   end
   arb_prio_enc #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc (.req(rot), .idx(enc_idx), .any_valid(any_req));
`else
   assign win_idx = enc_idx;
   arb_prio_enc #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_enc (.req(req), .idx(enc_idx), .any_valid(any_req));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
         wd          <= '0;
`ifdef ROUND_ROBIN_EN
         ptr         <= '0;
`endif
      end else begin
         timeout <= 1'b0;
         if (state == ST_IDLE) begin
            if (any_req) begin
               state       <= ST_BUSY;
               grant       <= NUM_REQ'(1) << win_idx;
               grant_idx   <= win_idx;
               grant_valid <= 1'b1;
               wd          <= '0;
`ifdef ROUND_ROBIN_EN
               ptr         <= win_idx;
`endif
            end
         end else if (done || wd == WD_LAST) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= !done;
            wd          <= '0;
         end else begin
            wd <= wd + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb_axi_lite_master_arbiter: vector table, corner sequences and randomized run against a reference model.
module tb_axi_lite_master_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int tests = 0;
   int fails = 0;
   bit inv_en = 1'b0;

   typedef struct {
      bit       v_rst;
      bit [3:0] v_req;
      bit       v_done;
      bit [3:0] e_grant;
      bit [1:0] e_idx;
      bit       e_valid;
      bit       e_to;
   } vec_t;
   vec_t tbl[$];

   bit m_busy;
   int m_idx;
   int m_age;
   int m_ptr;
   bit m_to;

   axi_lite_master_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int pick(bit [3:0] r);
`ifdef ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) if (r[(m_ptr - k + N) % N]) return (m_ptr - k + N) % N;
`else
      for (int m = N - 1; m >= 0; m--) if (r[m]) return m;
`endif
      return 0;
   endfunction

   // m_age = number of cycles the current grant has been visible
   task automatic model_step(bit r_rst, bit [3:0] r, bit d);
      if (r_rst) begin
         m_busy = 0; m_idx = 0; m_age = 0; m_ptr = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_busy) begin
            if (r != 0) begin
               m_idx = pick(r); m_ptr = m_idx; m_busy = 1; m_age = 1;
            end
         end else if (d) m_busy = 0;
         else if (m_age == TO) begin m_busy = 0; m_to = 1; end
         else m_age++;
      end
   endtask

   task automatic cyc(bit r_rst, bit [3:0] r, bit d);
      logic [7:0] exp;
      rst = r_rst; req = r; done = d;
      @(posedge clk);
      model_step(r_rst, r, d);
      #1;
      exp = {m_busy ? 4'(1 << m_idx) : 4'h0, m_busy ? 2'(m_idx) : 2'd0, m_busy, m_to};
      check("model", {grant, grant_idx, grant_valid, timeout}, 32'(exp));
   endtask

   always @(negedge clk) if (inv_en) begin
      tests++;
      if (grant_valid ? (grant !== (4'b1 << grant_idx)) : (grant !== 4'h0 || grant_idx !== 2'd0)) begin
         fails++;
         $display("FAIL onehot: grant %b idx %0d valid %b", grant, grant_idx, grant_valid);
      end
   end

   initial begin
      rst = 1'b1; req = 4'h0; done = 1'b0;
      model_step(1, 0, 0);
`ifndef ROUND_ROBIN_EN
      tbl.push_back('{1, 4'hf, 0, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{1, 4'hf, 0, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'hf, 0, 4'h8, 2'd3, 1, 0});
      tbl.push_back('{0, 4'h0, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h1, 0, 4'h1, 2'd0, 1, 0});
      tbl.push_back('{0, 4'h1, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h1, 0, 4'h1, 2'd0, 1, 0});
      tbl.push_back('{0, 4'ha, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'ha, 0, 4'h8, 2'd3, 1, 0});
      tbl.push_back('{0, 4'ha, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'ha, 0, 4'h8, 2'd3, 1, 0});
      tbl.push_back('{0, 4'h6, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h6, 0, 4'h4, 2'd2, 1, 0});
      tbl.push_back('{0, 4'h8, 0, 4'h4, 2'd2, 1, 0});
      tbl.push_back('{0, 4'h0, 0, 4'h4, 2'd2, 1, 0});
      tbl.push_back('{0, 4'h8, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h0, 1, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h0, 0, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'hf, 0, 4'h8, 2'd3, 1, 0});
      tbl.push_back('{1, 4'hf, 0, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{0, 4'h0, 0, 4'h0, 2'd0, 0, 0});
`else
      tbl.push_back('{1, 4'hf, 0, 4'h0, 2'd0, 0, 0});
      tbl.push_back('{1, 4'hf, 0, 4'h0, 2'd0, 0, 0});
`endif
      @(negedge clk);
      inv_en = 1'b1;
      foreach (tbl[i]) begin
         cyc(tbl[i].v_rst, tbl[i].v_req, tbl[i].v_done);
         check($sformatf("tbl%0d", i), {grant, grant_idx, grant_valid, timeout},
               {tbl[i].e_grant, tbl[i].e_idx, tbl[i].e_valid, tbl[i].e_to});
      end
      // watchdog expiry: grant visible for TO cycles, then one timeout pulse
      cyc(0, 4'h4, 0);
      for (int i = 1; i < TO; i++) begin
         cyc(0, 4'h0, 0);
         check("wd_hold", grant_valid, 1);
      end
      cyc(0, 4'h0, 0);
      check("wd_release", {grant_valid, timeout}, 2'b01);
      cyc(0, 4'h0, 0);
      check("wd_pulse_end", timeout, 0);
      // done on the expiry cycle wins: no pulse
      cyc(0, 4'h2, 0);
      for (int i = 1; i < TO; i++) cyc(0, 4'h0, 0);
      cyc(0, 4'h0, 1);
      check("wd_done_wins", {grant_valid, timeout}, 2'b00);
      // reset while busy: outputs clear, no pulse
      cyc(0, 4'h1, 0);
      cyc(1, 4'h1, 0);
      check("rst_busy", {grant, grant_idx, grant_valid, timeout}, 0);
`ifdef ROUND_ROBIN_EN
      begin
         bit [1:0] seq[5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
         for (int i = 0; i < 5; i++) begin
            cyc(0, 4'hf, 0);
            check($sformatf("rr%0d", i), grant_idx, seq[i]);
            cyc(0, 4'hf, 1);
         end
      end
`endif
      for (int i = 0; i < 3000; i++) begin
         bit r_rst = ($urandom_range(199) == 0);
         bit d = ($urandom_range(i % 500 < 250 ? 3 : 25) == 0);
         cyc(r_rst, 4'($urandom), d);
      end
      inv_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
